// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared mode encoding, brightness levels and sizing helpers for the LED animator
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COMET  = 2'd3
    } mode_e;

    function automatic int pos_width(int n);
        return $clog2(2 * n);
    endfunction

    function automatic int lvl_full(int w);
        return (1 << w) - 1;
    endfunction

    function automatic int lvl_half(int w);
        return 1 << (w - 1);
    endfunction

    function automatic int lvl_qtr(int w);
        return 1 << (w - 2);
    endfunction

    function automatic int period(mode_e m, int n);
        return m == MODE_FILL ? 2 * n : m == MODE_BOUNCE ? 2 * n - 2 : n;
    endfunction

endpackage

// File: rtl/led_anim_ctrl_step_timer.sv
// step_timer: prescaler producing one step pulse every max(load,1) enabled cycles
module step_timer
    import led_anim_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [STEP_W-1:0] load,
    output logic              step
);

    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] lim;

    assign lim  = load == '0 ? STEP_W'(1) : load;
    assign step = en && !clr && cnt >= lim - STEP_W'(1);

    // count enabled cycles; >= lets a lowered load wrap on the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= step ? '0 : cnt + STEP_W'(1);
    end

endmodule

// File: rtl/led_anim_ctrl.sv
// led_anim_ctrl: chase/fill/bounce/comet LED animator with step prescaler and PWM dimming
module led_anim_ctrl
    import led_anim_pkg::*;
#(
    parameter int N_LED  = 8,
    parameter int STEP_W = 16,
    parameter int PWM_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              enable,
    input  logic [STEP_W-1:0] step_load,
    output logic [N_LED-1:0]  led_out,
    output logic              frame_done
);

    localparam int PW = pos_width(N_LED);

    mode_e            mode_r;
    logic [PW-1:0]    pos;
    logic [PWM_W-1:0] pwm_cnt;
    logic [N_LED-1:0] pat;
    logic             chg;
    logic             step;
    logic             last;
    int               p;
    int               h;

    assign chg  = mode != mode_r;
    assign p    = int'(pos);
    assign h    = N_LED - 1 - p;
    assign last = p == period(mode_r, N_LED) - 1;

    function automatic int comet_lvl(int i, int hd);
        return i == hd ? lvl_full(PWM_W) :
               i == (hd + 1) % N_LED ? lvl_half(PWM_W) :
               i == (hd + 2) % N_LED ? lvl_qtr(PWM_W) : 0;
    endfunction

    step_timer #(.STEP_W(STEP_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (chg),
        .en   (enable),
        .load (step_load),
        .step (step)
    );

    // decode the current position into the LED pattern of the active mode
    always_comb begin
        pat = '0;
        for (int i = 0; i < N_LED; i++)
            pat[i] = mode_r == MODE_CHASE ? i == h :
                     mode_r == MODE_FILL  ? (p < N_LED ? i >= h : i < 2 * N_LED - 1 - p) :
                     mode_r == MODE_BOUNCE ? (p < N_LED ? i == h : i == p - N_LED + 1) :
                     comet_lvl(i, h) > int'(pwm_cnt);
    end

    // latch mode changes and advance the position; a mode change overrides any step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_CHASE;
            pos    <= '0;
        end else if (chg) begin
            mode_r <= mode_e'(mode);
            pos    <= '0;
        end else if (step) begin
            pos <= last ? '0 : pos + PW'(1);
        end
    end

    // free-running PWM counter for comet dimming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    // register the pattern and the frame wrap pulse; blanked on a mode change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            led_out    <= chg ? '0 : pat;
            frame_done <= !chg && step && last;
        end
    end

endmodule

// File: tb/tb_led_anim_ctrl.sv
// tb_led_anim_ctrl: scoreboard bench with a behavioural reference model for led_anim_ctrl
module tb_led_anim_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        enable;
    logic [15:0] step_load;
    logic [7:0]  led_out;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];

    int m_mode, m_pos, m_pre, m_pwm;
    int per[4] = '{8, 16, 14, 8};

    always #5 clk = ~clk;

    led_anim_ctrl #(.N_LED(8), .STEP_W(16), .PWM_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .enable     (enable),
        .step_load  (step_load),
        .led_out    (led_out),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_pat(input int m, input int p, input int c);
        logic [7:0] r;
        int hd;
        r = 8'hFF;
        hd = 7 - p;
        case (m)
            0: r = 8'h80 >> p;
            1: r = p < 8 ? ~(r >> (p + 1)) : r >> (p - 7);
            2: r = p < 8 ? 8'h80 >> p : 8'h01 << (p - 7);
            default: begin
                r = '0;
                if (31 > c) r[hd] = 1'b1;
                if (16 > c) r[(hd + 1) % 8] = 1'b1;
                if (8 > c)  r[(hd + 2) % 8] = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int lim;
        bit chg, stp;
        logic [7:0] e_led;
        bit e_fd;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_pre = 0; m_pwm = 0;
            exp_q.push_back(9'h0);
            return;
        end
        lim   = step_load == 0 ? 1 : int'(step_load);
        chg   = int'(mode) != m_mode;
        stp   = !chg && enable && (m_pre + 1 >= lim);
        e_led = chg ? 8'h00 : ref_pat(m_mode, m_pos, m_pwm);
        e_fd  = stp && (m_pos == per[m_mode] - 1);
        exp_q.push_back({e_fd, e_led});
        if (chg) begin
            m_mode = int'(mode); m_pos = 0; m_pre = 0;
        end else if (enable) begin
            m_pre = stp ? 0 : m_pre + 1;
            if (stp) m_pos = (m_pos + 1) % per[m_mode];
        end
        m_pwm = (m_pwm + 1) % 32;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_led", int'(led_out), int'(e[7:0]));
            check("sb_frame_done", int'(frame_done), int'(e[8]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt, c7, c0, c1, cx;
        logic [7:0] hold;
        rst = 1'b1; mode = 2'd0; enable = 1'b1; step_load = 16'd3;
        @(posedge clk); #1;
        check("reset_led", int'(led_out), 0);
        check("reset_fd", int'(frame_done), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("first_pattern", int'(led_out), 8'h80);
        cnt = 0;
        repeat (48) begin
            @(posedge clk); #1;
            cnt += int'(frame_done);
        end
        check("chase_fd_per_48", cnt, 2);
        @(negedge clk); mode = 2'd1; step_load = 16'd1;
        cyc(40);
        mode = 2'd2;
        cyc(30);
        mode = 2'd0;
        cyc(20);
        mode = 2'd2;
        @(posedge clk); #1;
        check("switch_blank", int'(led_out), 0);
        check("switch_no_fd", int'(frame_done), 0);
        @(posedge clk); #1;
        check("switch_new", int'(led_out), 8'h80);
        @(negedge clk); mode = 2'd0; step_load = 16'd2;
        cyc(9);
        enable = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        hold = led_out;
        repeat (8) begin
            @(posedge clk); #1;
            check("enable_hold", int'(led_out), int'(hold));
        end
        @(negedge clk); enable = 1'b1; mode = 2'd3; step_load = 16'd1000;
        @(posedge clk);
        c7 = 0; c0 = 0; c1 = 0; cx = 0;
        repeat (32) begin
            @(posedge clk); #1;
            c7 += int'(led_out[7]);
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
            cx += int'(led_out[6:2] != 5'd0);
        end
        check("comet_bit7", c7, 31);
        check("comet_bit0", c0, 16);
        check("comet_bit1", c1, 8);
        check("comet_others", cx, 0);
        @(negedge clk); step_load = 16'd1;
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            enable = $urandom_range(0, 5) != 0;
            if ($urandom_range(0, 9) == 0) step_load = 16'($urandom_range(0, 4));
        end
        mode = 2'd0; enable = 1'b1; step_load = 16'd2;
        cyc(7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", int'(led_out), 0);
        check("async_rst_fd", int'(frame_done), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("restart", int'(led_out), 8'h80);
        cyc(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
